// File: rtl/uart_led_command_pkg.sv
// Shared constants and state encodings for the UART LED command endpoint.
package uart_led_command_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  localparam logic [7:0] CMD_OFF      = 8'h30;
  localparam logic [7:0] CMD_ON       = 8'h31;
  localparam logic [7:0] CMD_TOG      = 8'h4C;
  localparam logic [7:0] CMD_LED1_ON  = 8'h32;
  localparam logic [7:0] CMD_LED1_OFF = 8'h33;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: mid-bit sampling, start-glitch rejection, framing-error discard.
module uart_rx
  import uart_led_command_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_q1, rx_s;
  rx_state_e       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Synchronizer resets high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rx_s, rx_q1} <= 2'b11;
    else      {rx_s, rx_q1} <= {rx_q1, rx};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= rx_s ? RX_DONE : RX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        RX_DONE: state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid = (state == RX_DONE);
  assign rx_byte  = shreg;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter with registered line output; start is ignored while busy.
module uart_tx
  import uart_led_command_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= TX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        TX_DATA: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else cnt <= cnt + 1'b1;
        end
        TX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= TX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign busy = (state != TX_IDLE);
endmodule

// File: rtl/uart_led_command_top.sv
// Board-level UART command endpoint: decodes ASCII LED commands and echoes every byte.
module uart_led_command_top
  import uart_led_command_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_pin,
  output logic       uart_tx_pin,
  output logic [7:0] led
);
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic [1:0] led_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx_pin),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  // Echo is dropped rather than queued when a previous echo is still going out.
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (rx_valid && !tx_busy),
    .data  (rx_byte),
    .tx    (uart_tx_pin),
    .busy  (tx_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= '0;
    else if (rx_valid) begin
      case (rx_byte)
        CMD_OFF:      led_q[0] <= 1'b0;
        CMD_ON:       led_q[0] <= 1'b1;
        CMD_TOG:      led_q[0] <= ~led_q[0];
        CMD_LED1_ON:  led_q[1] <= 1'b1;
        CMD_LED1_OFF: led_q[1] <= 1'b0;
        default:      ;
      endcase
    end
  end

  assign led = {6'b0, led_q};
endmodule

// File: tb/tb_uart_led_command_top.sv
// Directed bench: serial command frames in, LED state and decoded echo frames checked.
`timescale 1ns/1ps
module tb_uart_led_command_top;
  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       uart_tx_pin;
  logic [7:0] led;

  int         checks = 0;
  int         errors = 0;
  int         tx_count = 0;
  logic [7:0] last_echo = 8'h00;

  uart_led_command_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_pin (uart_rx_pin),
    .uart_tx_pin (uart_tx_pin),
    .led         (led)
  );

  always #50 clk = ~clk;

  // Echo decoder: mid-bit sampling of the DUT's serial output.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx_pin);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (uart_tx_pin == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 b[i] = uart_tx_pin;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (uart_tx_pin == 1'b1) begin
          last_echo = b;
          tx_count++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(posedge clk);
    #1 uart_rx_pin = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx_pin = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx_pin = good_stop;
    // A bad stop bit is released early so its tail is not taken for a new start bit.
    if (good_stop) repeat (CPB) @(posedge clk);
    else           repeat (58) @(posedge clk);
    #1 uart_rx_pin = 1'b1;
  endtask

  task automatic settle();
    repeat (1000) @(posedge clk);
    #1;
  endtask

  initial begin
    #200 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", 32'(led), 32'h00);
    chk("reset_tx_idle", 32'(uart_tx_pin), 32'h1);

    send_byte(8'h31, 1'b1); settle();
    chk("cmd1_led", 32'(led), 32'h01);
    chk("cmd1_echo_count", 32'(tx_count), 32'd1);
    chk("cmd1_echo_byte", 32'(last_echo), 32'h31);

    send_byte(8'h30, 1'b1); settle();
    chk("cmd0_led", 32'(led), 32'h00);
    chk("cmd0_echo_byte", 32'(last_echo), 32'h30);

    send_byte(8'h4C, 1'b1); settle();
    chk("tog1_led", 32'(led), 32'h01);
    send_byte(8'h4C, 1'b1); settle();
    chk("tog2_led", 32'(led), 32'h00);
    chk("tog2_echo_count", 32'(tx_count), 32'd4);

    send_byte(8'h32, 1'b1); settle();
    chk("cmd2_led", 32'(led), 32'h02);

    send_byte(8'h41, 1'b1); settle();
    chk("other_led", 32'(led), 32'h02);
    chk("other_echo_byte", 32'(last_echo), 32'h41);
    chk("other_echo_count", 32'(tx_count), 32'd6);

    @(posedge clk);
    #30 uart_rx_pin = 1'b0;
    #40 uart_rx_pin = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("glitch_led", 32'(led), 32'h02);
    chk("glitch_echo_count", 32'(tx_count), 32'd6);

    send_byte(8'h31, 1'b0); settle();
    chk("frame_err_led", 32'(led), 32'h02);
    chk("frame_err_echo_count", 32'(tx_count), 32'd6);
    chk("frame_err_tx_idle", 32'(uart_tx_pin), 32'h1);

    send_byte(8'h33, 1'b1); settle();
    chk("cmd3_led", 32'(led), 32'h00);
    chk("cmd3_echo_byte", 32'(last_echo), 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
